// File: rtl/pqsdn_tcam_pkg.sv
// ---------------------------------------------------------------------------
// pqsdn_tcam_pkg
//   Shared definitions for the SDN match-stage ternary CAM.
//   - Default key / index widths used by the top-level parameters.
//   - Index reported on a lookup miss.
//   - Decoded write-port operation type.
// ---------------------------------------------------------------------------
package pqsdn_tcam_pkg;

    // Default geometry: 64-bit keys, 2**6 = 64 entries.
    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 6;

    // Index driven on res_addr_o when nothing matches.
    localparam int MISS_ADDR  = 0;

    // One write-port operation per cycle. Flush outranks install/delete.
    typedef enum logic [1:0] {
        WR_NONE    = 2'd0,
        WR_INSTALL = 2'd1,
        WR_DELETE  = 2'd2,
        WR_FLUSH   = 2'd3
    } wr_op_e;

endpackage

// File: rtl/pqsdn_tcam_prio_enc.sv
// ---------------------------------------------------------------------------
// pqsdn_prio_enc
//   Combinational lowest-index priority encoder.
//   Ports:
//     vec_i    in  N       request vector
//     idx_o    out IDX_W   index of the lowest set bit (0 if none)
//     any_o    out 1       at least one bit set
//     multi_o  out 1       more than one bit set
// ---------------------------------------------------------------------------
module pqsdn_prio_enc #(
    parameter int N     = 64,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic             multi_o
);

    always_comb begin
        idx_o = '0;
        // Scan from the top down so the last assignment is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o   = |vec_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(vec_i & (vec_i - N'(1)));

endmodule

// File: rtl/pqsdn_tcam.sv
// ---------------------------------------------------------------------------
// pqsdn_tcam
//   Parametrised ternary CAM for the SDN match stage. DEPTH = 2**ADDR_W
//   entries of {key, care-mask, valid}. Two-stage lookup pipeline:
//     S1 registers the per-entry match vector,
//     S2 priority-encodes it and registers the result.
//   Handshakes: a request transfers on a cycle where lk_valid_i && lk_ready_o;
//   a result transfers on a cycle where res_valid_o && res_ready_i. A valid
//   result holds all its fields stable until it transfers.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     wr_en_i         write/delete strobe
//     wr_addr_i       target entry
//     wr_key_i        entry key
//     wr_mask_i       care mask (1 = compared, 0 = wildcard)
//     wr_valid_i      1 = install, 0 = delete
//     flush_i         invalidate every entry at the next edge
//     lk_valid_i      lookup request valid
//     lk_ready_o      lookup request accepted
//     lk_key_i        search key
//     res_valid_o     result valid
//     res_ready_i     result consumed
//     res_hit_o       at least one entry matched
//     res_addr_o      lowest matching index (MISS_ADDR on miss)
//     res_multi_o     more than one entry matched
//     occupancy_o     number of valid entries
// ---------------------------------------------------------------------------
module pqsdn_tcam
    import pqsdn_tcam_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_key_i,
    input  logic [DATA_W-1:0] wr_mask_i,
    input  logic              wr_valid_i,
    input  logic              flush_i,
    input  logic              lk_valid_i,
    output logic              lk_ready_o,
    input  logic [DATA_W-1:0] lk_key_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              res_hit_o,
    output logic [ADDR_W-1:0] res_addr_o,
    output logic              res_multi_o,
    output logic [ADDR_W:0]   occupancy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    // ---------------------------------------------------------------
    // Entry storage. Key/mask carry no reset; valid_q gates them.
    // ---------------------------------------------------------------
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] key_q  [DEPTH];
    logic [DATA_W-1:0] mask_q [DEPTH];
    logic [CNT_W-1:0]  occ_q, occ_d;

    wr_op_e wr_op;

    always_comb begin
        wr_op = WR_NONE;
        if (flush_i) begin
            wr_op = WR_FLUSH;
        end else if (wr_en_i) begin
            wr_op = wr_valid_i ? WR_INSTALL : WR_DELETE;
        end
    end

    // The count changes only on a real valid-bit transition, so it is exact
    // and never needs to saturate.
    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        case (wr_op)
            WR_FLUSH: begin
                valid_d = '0;
                occ_d   = '0;
            end
            WR_INSTALL: begin
                valid_d[wr_addr_i] = 1'b1;
                if (!valid_q[wr_addr_i]) begin
                    occ_d = occ_q + CNT_W'(1);
                end
            end
            WR_DELETE: begin
                valid_d[wr_addr_i] = 1'b0;
                if (valid_q[wr_addr_i]) begin
                    occ_d = occ_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_op == WR_INSTALL) begin
            key_q[wr_addr_i]  <= wr_key_i;
            mask_q[wr_addr_i] <= wr_mask_i;
        end
    end

    assign occupancy_o = occ_q;

    // ---------------------------------------------------------------
    // Lookup handshake. The compare uses the array as it stands in the
    // accept cycle, so a same-cycle write is not visible to that lookup.
    // ---------------------------------------------------------------
    logic stall;
    logic lk_accept;

    assign stall      = res_valid_o && !res_ready_i;
    assign lk_ready_o = rst_n && !stall && !flush_i;
    assign lk_accept  = lk_valid_i && lk_ready_o;

    logic [DEPTH-1:0] match_vec;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_q[i] &&
                           (((lk_key_i ^ key_q[i]) & mask_q[i]) == '0);
        end
    end

    // ---------------------------------------------------------------
    // S1: match vector register.
    // ---------------------------------------------------------------
    logic             s1_valid_q;
    logic [DEPTH-1:0] s1_vec_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_vec_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= lk_accept;
            s1_vec_q   <= match_vec;
        end
    end

    // ---------------------------------------------------------------
    // S2: priority encode and result register.
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] enc_idx;
    logic              enc_any;
    logic              enc_multi;

    pqsdn_prio_enc #(
        .N     (DEPTH),
        .IDX_W (ADDR_W)
    ) u_prio_enc (
        .vec_i   (s1_vec_q),
        .idx_o   (enc_idx),
        .any_o   (enc_any),
        .multi_o (enc_multi)
    );

    logic              res_valid_q, res_valid_d;
    logic              res_hit_q,   res_hit_d;
    logic [ADDR_W-1:0] res_addr_q,  res_addr_d;
    logic              res_multi_q, res_multi_d;

    always_comb begin
        res_valid_d = s1_valid_q;
        res_hit_d   = 1'b0;
        res_multi_d = 1'b0;
        res_addr_d  = ADDR_W'(MISS_ADDR);
        if (s1_valid_q && enc_any) begin
            res_hit_d   = 1'b1;
            res_multi_d = enc_multi;
            res_addr_d  = enc_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_addr_q  <= '0;
            res_multi_q <= 1'b0;
        end else if (!stall) begin
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            res_addr_q  <= res_addr_d;
            res_multi_q <= res_multi_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_hit_o   = res_hit_q;
    assign res_addr_o  = res_addr_q;
    assign res_multi_o = res_multi_q;

endmodule

// File: tb/tb_pqsdn_tcam.sv
// ---------------------------------------------------------------------------
// tb_pqsdn_tcam
//   Directed bench for pqsdn_tcam. Inputs change 1 time unit after the
//   rising edge; the monitor samples on the falling edge. Every accepted
//   lookup pushes its hand-computed {hit, multi, addr} onto exp_q; every
//   consumed result is popped and compared in order.
// ---------------------------------------------------------------------------
module tb_pqsdn_tcam;
    import pqsdn_tcam_pkg::*;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [DATA_W-1:0] ALL1 = {DATA_W{1'b1}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_key_i;
    logic [DATA_W-1:0] wr_mask_i;
    logic              wr_valid_i;
    logic              flush_i;
    logic              lk_valid_i;
    logic              lk_ready_o;
    logic [DATA_W-1:0] lk_key_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic              res_hit_o;
    logic [ADDR_W-1:0] res_addr_o;
    logic              res_multi_o;
    logic [CNT_W-1:0]  occupancy_o;

    pqsdn_tcam #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_key_i    (wr_key_i),
        .wr_mask_i   (wr_mask_i),
        .wr_valid_i  (wr_valid_i),
        .flush_i     (flush_i),
        .lk_valid_i  (lk_valid_i),
        .lk_ready_o  (lk_ready_o),
        .lk_key_i    (lk_key_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_hit_o   (res_hit_o),
        .res_addr_o  (res_addr_o),
        .res_multi_o (res_multi_o),
        .occupancy_o (occupancy_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] lk_exp;
    logic       lk_acc;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] mk(input bit hit, input bit multi, input int addr);
        return {hit, multi, 6'(addr)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        logic [7:0] e;
        lk_acc = 1'b0;
        if (rst_n) begin
            if (res_valid_o && !res_ready_i) check_eq("stall_ready", 64'(lk_ready_o), 64'd0);
            if (flush_i) check_eq("flush_ready", 64'(lk_ready_o), 64'd0);
            if (res_valid_o && res_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("result", 64'({res_hit_o, res_multi_o, res_addr_o}), 64'(e));
                end
            end
            if (lk_valid_i && lk_ready_o) begin
                exp_q.push_back(lk_exp);
                lk_acc = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] k, input logic [DATA_W-1:0] m,
                      input bit v);
        wr_en_i    = 1'b1;
        wr_addr_i  = 6'(a);
        wr_key_i   = k;
        wr_mask_i  = m;
        wr_valid_i = v;
        tick();
        wr_en_i    = 1'b0;
    endtask

    task automatic lookup(input logic [DATA_W-1:0] k, input logic [7:0] e);
        lk_valid_i = 1'b1;
        lk_key_i   = k;
        lk_exp     = e;
        tick();
        lk_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] keys [4];
    logic [7:0]        exps [4];

    initial begin
        rst_n = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_key_i = '0; wr_mask_i = '0;
        wr_valid_i = 1'b0; flush_i = 1'b0; lk_valid_i = 1'b0; lk_key_i = '0;
        res_ready_i = 1'b1; lk_exp = '0;

        // Reset state
        tick(); tick();
        check_eq("rst_res_valid", 64'(res_valid_o), 64'd0);
        check_eq("rst_lk_ready",  64'(lk_ready_o),  64'd0);
        check_eq("rst_occ",       64'(occupancy_o), 64'd0);
        check_eq("rst_hit",       64'(res_hit_o),   64'd0);
        check_eq("rst_addr",      64'(res_addr_o),  64'd0);
        rst_n = 1'b1;
        tick();

        // Empty-table lookup and two-cycle latency
        lk_valid_i = 1'b1; lk_key_i = 64'h1; lk_exp = mk(0, 0, 0);
        tick();
        lk_valid_i = 1'b0;
        check_eq("lat_t1_valid", 64'(res_valid_o), 64'd0);
        tick();
        check_eq("lat_t2_valid", 64'(res_valid_o), 64'd1);
        check_eq("miss_hit",     64'(res_hit_o),   64'd0);
        check_eq("miss_addr",    64'(res_addr_o),  64'd0);
        check_eq("miss_occ",     64'(occupancy_o), 64'd0);
        drain();

        // Exact entry at 5
        wr(5, 64'hAB, ALL1, 1'b1);
        check_eq("occ_after_5", 64'(occupancy_o), 64'd1);
        lookup(64'hAB, mk(1, 0, 5));
        drain();

        // Wildcard at 3 wins on lower index, both match
        wr(3, 64'h0, 64'h0, 1'b1);
        check_eq("occ_after_3", 64'(occupancy_o), 64'd2);
        lookup(64'hAB, mk(1, 1, 3));
        lookup(64'h1,  mk(1, 0, 3));
        drain();

        // Remove wildcard, then write @7 and look up its key in the same cycle
        wr(3, 64'h0, 64'h0, 1'b0);
        check_eq("occ_del_3", 64'(occupancy_o), 64'd1);
        wr_en_i = 1'b1; wr_addr_i = 6'd7; wr_key_i = 64'h1234; wr_mask_i = ALL1; wr_valid_i = 1'b1;
        lk_valid_i = 1'b1; lk_key_i = 64'h1234; lk_exp = mk(0, 0, 0);
        tick();
        wr_en_i = 1'b0;
        lk_exp = mk(1, 0, 7);
        tick();
        lk_valid_i = 1'b0;
        drain();
        check_eq("occ_after_7", 64'(occupancy_o), 64'd2);

        // Four back-to-back lookups with a three-cycle result stall
        keys[0] = 64'hAB;   exps[0] = mk(1, 0, 5);
        keys[1] = 64'h1234; exps[1] = mk(1, 0, 7);
        keys[2] = 64'h0;    exps[2] = mk(0, 0, 0);
        keys[3] = 64'hAB;   exps[3] = mk(1, 0, 5);
        begin
            int i = 0;
            int cyc = 0;
            while (i < 4 && cyc < 40) begin
                lk_valid_i  = 1'b1;
                lk_key_i    = keys[i];
                lk_exp      = exps[i];
                res_ready_i = !(cyc >= 2 && cyc <= 4);
                tick();
                if (lk_acc) i++;
                cyc++;
            end
            check_eq("stall_all_issued", 64'(i), 64'd4);
        end
        lk_valid_i  = 1'b0;
        res_ready_i = 1'b1;
        drain();

        // Flush with two lookups in flight and a concurrent write @9
        lookup(64'hAB,   mk(1, 0, 5));
        lk_valid_i = 1'b1; lk_key_i = 64'h1234; lk_exp = mk(1, 0, 7);
        tick();
        lk_key_i = 64'h99; lk_exp = mk(0, 0, 0);
        flush_i = 1'b1;
        wr_en_i = 1'b1; wr_addr_i = 6'd9; wr_key_i = 64'h99; wr_mask_i = ALL1; wr_valid_i = 1'b1;
        tick();
        flush_i = 1'b0; wr_en_i = 1'b0; lk_valid_i = 1'b0;
        check_eq("flush_occ", 64'(occupancy_o), 64'd0);
        drain();
        lookup(64'h99, mk(0, 0, 0));
        lookup(64'hAB, mk(0, 0, 0));
        drain();

        // Overwrite and double delete keep the count exact
        wr(5, 64'hAB, ALL1, 1'b1);
        wr(6, 64'h66, ALL1, 1'b1);
        check_eq("occ_two", 64'(occupancy_o), 64'd2);
        wr(6, 64'h66, ALL1, 1'b1);
        check_eq("occ_overwrite", 64'(occupancy_o), 64'd2);
        wr(5, 64'h0, 64'h0, 1'b0);
        check_eq("occ_del_once", 64'(occupancy_o), 64'd1);
        wr(5, 64'h0, 64'h0, 1'b0);
        check_eq("occ_del_twice", 64'(occupancy_o), 64'd1);
        lookup(64'hAB, mk(0, 0, 0));
        lookup(64'h66, mk(1, 0, 6));
        drain();

        // Reset mid-flight drops in-flight lookups
        lk_valid_i = 1'b1; lk_key_i = 64'h66; lk_exp = mk(1, 0, 6);
        tick();
        rst_n = 1'b0;
        tick();
        lk_valid_i = 1'b0;
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        check_eq("mid_rst_valid", 64'(res_valid_o), 64'd0);
        check_eq("mid_rst_occ",   64'(occupancy_o), 64'd0);
        tick(); tick();
        check_eq("mid_rst_no_result", 64'(res_valid_o), 64'd0);
        lookup(64'h66, mk(0, 0, 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
